// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared constants for the timed output block
package timing_pkg;

   // Control FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_END   = 2'd2;
   localparam logic [1:0] ST_ERROR = 2'd3;

   // Bit positions inside the packed status vector
   localparam int STAT_RUN   = 0;
   localparam int STAT_END   = 1;
   localparam int STAT_ERROR = 2;
   localparam int STAT_BITS  = 3;

   // Sample word layout: {time, data}, data in the low bits
   localparam int DATA_LSB = 0;

   // The time field sits directly above the data field
   function automatic int time_lsb(input int data_bits);
      return data_bits;
   endfunction

endpackage

// File: rtl/timed_output_if.sv
// rtl/timed_output_if.sv - sample word handshake between stream buffer and timed output
interface timed_output_if #(
   parameter int TIME_BITS = 32,
   parameter int DATA_BITS = 32
);
   logic [TIME_BITS+DATA_BITS-1:0] in_data;
   logic                           in_valid;
   logic                           in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/timer_tick_gen.sv
// rtl/timer_tick_gen.sv - clock prescaler and tick counter
module timer_tick_gen #(
   parameter int TIME_BITS = 32,
   parameter int CLK_DIV   = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   output logic                 tick,
   output logic [TIME_BITS-1:0] timer,
   output logic                 overflow
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] prescaler;

   // A tick closes each CLK_DIV-cycle window, so every timer value lasts CLK_DIV cycles
   assign tick     = enable && (prescaler == PW'(CLK_DIV - 1));
   assign overflow = tick && (timer == '1);

   // Prescaler and timer advance only while enabled; clear restarts both from zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         timer     <= '0;
      end else if (clear) begin
         prescaler <= '0;
         timer     <= '0;
      end else if (enable) begin
         if (tick) begin
            prescaler <= '0;
            timer     <= timer + 1'b1;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end
endmodule

// File: rtl/timed_output.sv
// rtl/timed_output.sv - holds one timed sample and drives it out when the timer matches
module timed_output
   import timing_pkg::*;
#(
   parameter int TIME_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int CLK_DIV   = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run,
   input  logic [31:0]          num_samples,
   timed_output_if.slave        s_in,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_strobe,
   output logic [31:0]          sample_count,
   output logic [TIME_BITS-1:0] timer,
   output logic                 status_run,
   output logic                 status_end,
   output logic                 status_error
);
   localparam int TIME_LSB = time_lsb(DATA_BITS);

   logic [1:0]           state;
   logic                 run_q;
   logic                 primed;
   logic                 hold_valid;
   logic [TIME_BITS-1:0] hold_time;
   logic [DATA_BITS-1:0] hold_data;
   logic [31:0]          num_lat;
   logic [STAT_BITS-1:0] status;

   logic tick, overflow, start, in_run;
   logic late, ovf_err, err, fire, last, load, in_ready_w;

   assign in_run  = (state == ST_RUN);
   assign start   = (state == ST_IDLE) && run && !run_q;
   assign late    = in_run && hold_valid && (hold_time < timer);
   assign ovf_err = in_run && overflow && (sample_count != num_lat);
   assign err     = late || ovf_err;
   // run=0 and errors both pre-empt an output in the same cycle
   assign fire    = in_run && run && !err && tick && hold_valid && (hold_time == timer);
   assign last    = fire && ((sample_count + 32'd1) == num_lat);
   // The final fire does not take a new word so leftover stream data stays upstream
   assign in_ready_w = in_run && run && !err && (!hold_valid || fire) && !last;
   assign load       = s_in.in_valid && in_ready_w;

   assign s_in.in_ready = in_ready_w;

   assign status[STAT_RUN]   = (state == ST_RUN);
   assign status[STAT_END]   = (state == ST_END);
   assign status[STAT_ERROR] = (state == ST_ERROR);
   assign status_run   = status[STAT_RUN];
   assign status_end   = status[STAT_END];
   assign status_error = status[STAT_ERROR];

   // The first RUN cycle only primes the hold register; the timer starts on the next one
   timer_tick_gen #(
      .TIME_BITS (TIME_BITS),
      .CLK_DIV   (CLK_DIV)
   ) u_tick (
      .clock    (clock),
      .reset    (reset),
      .enable   (in_run && primed),
      .clear    (start),
      .tick     (tick),
      .timer    (timer),
      .overflow (overflow)
   );

   // Control FSM, hold register and output register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         run_q        <= 1'b0;
         primed       <= 1'b0;
         hold_valid   <= 1'b0;
         hold_time    <= '0;
         hold_data    <= '0;
         num_lat      <= '0;
         out_data     <= '0;
         out_strobe   <= 1'b0;
         sample_count <= '0;
      end else begin
         run_q      <= run;
         out_strobe <= 1'b0;
         if (load) begin
            hold_time <= s_in.in_data[TIME_LSB +: TIME_BITS];
            hold_data <= s_in.in_data[DATA_LSB +: DATA_BITS];
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  num_lat      <= num_samples;
                  sample_count <= '0;
                  primed       <= 1'b0;
                  hold_valid   <= 1'b0;
                  state        <= (num_samples == 32'd0) ? ST_END : ST_RUN;
               end
            end
            ST_RUN: begin
               if (!run) begin
                  state      <= ST_IDLE;
                  hold_valid <= 1'b0;
               end else if (err) begin
                  state <= ST_ERROR;
               end else begin
                  primed     <= 1'b1;
                  hold_valid <= load || (hold_valid && !fire);
                  if (fire) begin
                     out_data     <= hold_data;
                     out_strobe   <= 1'b1;
                     sample_count <= sample_count + 32'd1;
                  end
                  if (last) state <= ST_END;
               end
            end
            default: begin
               if (!run) begin
                  state      <= ST_IDLE;
                  hold_valid <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_timed_output.sv
// tb/tb_timed_output.sv - directed bench for timed_output
module tb_timed_output;
   localparam int TB = 32;
   localparam int DB = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          run1 = 1'b0, run4 = 1'b0;
   logic [31:0]   num1 = '0, num4 = '0;
   logic [DB-1:0] out_data1, out_data4;
   logic          out_strobe1, out_strobe4;
   logic [31:0]   sample_count1, sample_count4;
   logic [TB-1:0] timer1, timer4;
   logic          status_run1, status_end1, status_error1;
   logic          status_run4, status_end4, status_error4;

   timed_output_if #(.TIME_BITS(TB), .DATA_BITS(DB)) sif1 ();
   timed_output_if #(.TIME_BITS(TB), .DATA_BITS(DB)) sif4 ();

   timed_output #(.TIME_BITS(TB), .DATA_BITS(DB), .CLK_DIV(1)) dut1 (
      .clock(clock), .reset(reset), .run(run1), .num_samples(num1), .s_in(sif1),
      .out_data(out_data1), .out_strobe(out_strobe1), .sample_count(sample_count1),
      .timer(timer1), .status_run(status_run1), .status_end(status_end1),
      .status_error(status_error1)
   );

   timed_output #(.TIME_BITS(TB), .DATA_BITS(DB), .CLK_DIV(4)) dut4 (
      .clock(clock), .reset(reset), .run(run4), .num_samples(num4), .s_in(sif4),
      .out_data(out_data4), .out_strobe(out_strobe4), .sample_count(sample_count4),
      .timer(timer4), .status_run(status_run4), .status_end(status_end4),
      .status_error(status_error4)
   );

   logic [63:0] q1[$];
   logic [63:0] q4[$];
   logic        en1 = 1'b1, en4 = 1'b1;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic [63:0] w(input logic [31:0] t, input logic [31:0] d);
      return {t, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      sif1.in_valid = en1 && (q1.size() != 0);
      sif1.in_data  = (q1.size() != 0) ? q1[0] : '0;
      sif4.in_valid = en4 && (q4.size() != 0);
      sif4.in_data  = (q4.size() != 0) ? q4[0] : '0;
   endtask

   // One clock: pop accepted words, re-drive sources, return at the falling edge
   task automatic step();
      logic a1, a4;
      #1;
      a1 = sif1.in_valid && sif1.in_ready;
      a4 = sif4.in_valid && sif4.in_ready;
      @(posedge clock);
      #1;
      if (a1 && q1.size() != 0) q1.delete(0);
      if (a4 && q4.size() != 0) q4.delete(0);
      drive();
      @(negedge clock);
   endtask

   int          s_idx[2];
   logic [31:0] s_dat[2];
   logic [31:0] s_tim[2];
   int          ns;
   logic [31:0] t_prev;
   logic        seen;

   initial begin
      drive();
      repeat (2) @(negedge clock);
      chk("rst_out_data", out_data1, 0);
      chk("rst_strobe", out_strobe1, 0);
      chk("rst_count", sample_count1, 0);
      chk("rst_timer", timer1, 0);
      chk("rst_ready", sif1.in_ready, 0);
      chk("rst_status", {status_run1, status_end1, status_error1}, 0);
      chk("rst_status4", {status_run4, status_end4, status_error4, sif4.in_ready}, 0);
      reset = 1'b0;
      @(negedge clock);

      // back-to-back samples at times 0,1,2 with a spare word behind them
      q1 = {w(0, 'hA), w(1, 'hB), w(2, 'hC), w(3, 'hD)};
      drive(); num1 = 3; run1 = 1'b1;
      step();
      chk("t1_c0_ready", sif1.in_ready, 1);
      step();
      chk("t1_c1_strobe", out_strobe1, 0);
      step();
      chk("t1_a", {out_strobe1, out_data1}, {1'b1, 32'hA});
      step();
      chk("t1_b", {out_strobe1, out_data1}, {1'b1, 32'hB});
      step();
      chk("t1_c", {out_strobe1, out_data1}, {1'b1, 32'hC});
      chk("t1_count", sample_count1, 3);
      chk("t1_end", {status_end1, status_run1, sif1.in_ready}, 3'b100);
      step();
      chk("t1_strobe_after", out_strobe1, 0);
      chk("t1_unconsumed", q1.size(), 1);

      // CLK_DIV=4 instance: samples at times 2 and 5
      q4 = {w(2, 'h11), w(5, 'h22)};
      drive(); num4 = 2; run4 = 1'b1;
      step();
      ns = 0;
      for (int i = 1; i <= 40; i++) begin
         t_prev = timer4;
         step();
         if (out_strobe4 && ns < 2) begin
            s_idx[ns] = i; s_dat[ns] = out_data4; s_tim[ns] = t_prev;
            ns++;
         end
      end
      chk("t2_strobes", ns, 2);
      chk("t2_first_cycle", s_idx[0], 13);
      chk("t2_first_data", s_dat[0], 'h11);
      chk("t2_first_timer", s_tim[0], 2);
      chk("t2_spacing", s_idx[1] - s_idx[0], 12);
      chk("t2_second_data", s_dat[1], 'h22);
      chk("t2_second_timer", s_tim[1], 5);
      chk("t2_end", {status_end4, sample_count4}, {1'b1, 32'd2});

      // non-increasing times 3,3
      run1 = 1'b0; step();
      q1.delete();
      q1 = {w(3, 'h1), w(3, 'h2)};
      drive(); num1 = 2; run1 = 1'b1;
      step();
      repeat (4) step();
      chk("t3_c4_strobe", out_strobe1, 0);
      step();
      chk("t3_fire", {out_strobe1, out_data1}, {1'b1, 32'h1});
      chk("t3_no_err_yet", status_error1, 0);
      step();
      chk("t3_error", {status_error1, status_run1}, 2'b10);
      chk("t3_hold_out", {out_strobe1, out_data1}, {1'b0, 32'h1});
      chk("t3_ready", sif1.in_ready, 0);
      chk("t3_count", sample_count1, 1);

      // underflow: word for time 5 offered only once timer reaches 10
      run1 = 1'b0; step();
      q1.delete();
      q1 = {w(5, 'h7)};
      en1 = 1'b0; drive(); num1 = 1; run1 = 1'b1;
      step();
      seen = 1'b0;
      for (int i = 0; i < 30 && timer1 != 10; i++) begin
         step();
         seen = seen | out_strobe1;
      end
      chk("t4_timer10", timer1, 10);
      en1 = 1'b1; drive();
      step();
      seen = seen | out_strobe1;
      chk("t4_accepted", q1.size(), 0);
      chk("t4_not_yet", status_error1, 0);
      step();
      seen = seen | out_strobe1;
      chk("t4_error", status_error1, 1);
      chk("t4_no_strobe", seen, 0);

      // run dropped while a sample for time 9 is held
      run1 = 1'b0; step();
      q1.delete();
      q1 = {w(9, 'h5)};
      drive(); num1 = 1; run1 = 1'b1;
      step();
      repeat (5) step();
      chk("t5_timer4", {status_run1, timer1}, {1'b1, 32'd4});
      run1 = 1'b0;
      step();
      chk("t5_idle", {status_run1, status_end1, status_error1}, 0);
      chk("t5_out_kept", {out_strobe1, out_data1}, {1'b0, 32'h1});
      chk("t5_ready_idle", sif1.in_ready, 0);
      run1 = 1'b1;
      step();
      chk("t5_restart_timer", timer1, 0);
      chk("t5_restart_count", sample_count1, 0);
      chk("t5_restart_ready", {status_run1, sif1.in_ready}, 2'b11);

      // asynchronous reset between edges
      repeat (3) step();
      chk("t6_timer_running", timer1, 2);
      #2;
      reset = 1'b1; run1 = 1'b0;
      #1;
      chk("t6_out_data", out_data1, 0);
      chk("t6_timer", timer1, 0);
      chk("t6_count_strobe", {sample_count1, out_strobe1}, 0);
      chk("t6_state", {status_run1, status_end1, status_error1, sif1.in_ready}, 0);
      @(negedge clock);
      reset = 1'b0;

      // zero-sample run ends immediately without taking data
      q1.delete();
      q1 = {w(0, 'hE)};
      drive(); num1 = 0; run1 = 1'b1;
      step();
      chk("t7_end", {status_end1, status_run1, sif1.in_ready}, 3'b100);
      step();
      chk("t7_unconsumed", q1.size(), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
